// File: rtl/next_pc_unit_pkg.sv
// Shared types and constants for the next-PC unit.
package next_pc_unit_pkg;
  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} pc_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES  = 32'd4;
endpackage

// File: rtl/next_pc_unit_branch_target_calc.sv
// Branch and jump target formation from the sequential PC.
module branch_target_calc
  import next_pc_unit_pkg::*;
(
  input  logic [31:0] i_pc_plus4,
  input  logic [31:0] i_imm_ext,
  input  logic [25:0] i_jump_addr,
  output logic [31:0] o_branch_tgt,
  output logic [31:0] o_jump_tgt
);
  // Word offset: the top two immediate bits fall off, add wraps mod 2^32.
  assign o_branch_tgt = i_pc_plus4 + {i_imm_ext[29:0], 2'b00};
  assign o_jump_tgt   = {i_pc_plus4[31:28], i_jump_addr, 2'b00};
endmodule

// File: rtl/next_pc_unit.sv
// PC register with next-PC selection, misaligned-jr trap and redirect counter.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             branch_ne_i,
  input  logic             zero_i,
  input  logic [31:0]      imm_ext_i,
  input  logic             jump_i,
  input  logic [25:0]      jump_addr_i,
  input  logic             jr_i,
  input  logic [31:0]      rs_data_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             redirect_o,
  output logic             trap_o,
  output logic [31:0]      epc_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);
  pc_state_e        r_state, w_state_nxt;
  logic [31:0]      r_pc, r_epc, w_pc_nxt;
  logic [31:0]      w_branch_tgt, w_jump_tgt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_redirect, w_redirect, w_fault, w_taken;

  assign pc_plus4_o = r_pc + INSTR_BYTES;
  assign w_taken    = (branch_i & zero_i) | (branch_ne_i & ~zero_i);

  branch_target_calc u_tgt (
    .i_pc_plus4   (pc_plus4_o),
    .i_imm_ext    (imm_ext_i),
    .i_jump_addr  (jump_addr_i),
    .o_branch_tgt (w_branch_tgt),
    .o_jump_tgt   (w_jump_tgt)
  );

  always_comb begin
    w_pc_nxt   = r_pc;
    w_redirect = 1'b0;
    w_fault    = 1'b0;
    if (r_state == RUN && !stall_i) begin
      if (jr_i) begin
        if (rs_data_i[1:0] != 2'b00) w_fault = 1'b1;
        else begin
          w_pc_nxt   = rs_data_i;
          w_redirect = 1'b1;
        end
      end else if (jump_i) begin
        w_pc_nxt   = w_jump_tgt;
        w_redirect = 1'b1;
      end else if (w_taken) begin
        w_pc_nxt   = w_branch_tgt;
        w_redirect = 1'b1;
      end else begin
        w_pc_nxt = pc_plus4_o;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // TRAP is absorbing; only reset leaves it.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN && w_fault) w_state_nxt = TRAP;
  end

  always_comb begin
    trap_o = (r_state == TRAP);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_pc       <= RESET_PC;
      r_epc      <= '0;
      r_redirect <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_redirect <= w_redirect;
      if (w_fault) r_epc <= r_pc;
      if (w_redirect && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign pc_o           = r_pc;
  assign epc_o          = r_epc;
  assign redirect_o     = r_redirect;
  assign redirect_cnt_o = r_cnt;
endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit (CNT_W=4 to reach saturation).
module tb_next_pc_unit;
  logic        clk = 1'b0;
  logic        rst, stall, branch, branch_ne, zero, jump, jr;
  logic [31:0] imm_ext, rs_data;
  logic [25:0] jump_addr;
  logic [31:0] pc, pc_plus4, epc;
  logic        redirect, trap;
  logic [3:0]  cnt;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  next_pc_unit #(.RESET_PC(32'h0), .CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .branch_i       (branch),
    .branch_ne_i    (branch_ne),
    .zero_i         (zero),
    .imm_ext_i      (imm_ext),
    .jump_i         (jump),
    .jump_addr_i    (jump_addr),
    .jr_i           (jr),
    .rs_data_i      (rs_data),
    .pc_o           (pc),
    .pc_plus4_o     (pc_plus4),
    .redirect_o     (redirect),
    .trap_o         (trap),
    .epc_o          (epc),
    .redirect_cnt_o (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch = 0; branch_ne = 0; zero = 0; jump = 0; jr = 0;
    imm_ext = '0; rs_data = '0; jump_addr = '0;
  endtask

  task automatic chk_st(input string tag, input logic [31:0] e_pc, input logic e_rd,
                        input logic [3:0] e_cnt);
    chk({tag, ".pc"},  pc, e_pc);
    chk({tag, ".rd"},  {31'b0, redirect}, {31'b0, e_rd});
    chk({tag, ".cnt"}, {28'b0, cnt}, {28'b0, e_cnt});
  endtask

  initial begin
    idle();
    rst = 0;
    tick();
    chk_st("reset", 32'h0, 1'b0, 4'd0);
    chk("reset.trap", {31'b0, trap}, 32'd0);
    chk("reset.epc", epc, 32'd0);

    rst = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_st("freerun", 32'(4 * i), 1'b0, 4'd0);
    end
    repeat (13) tick();
    chk("pc40", pc, 32'h40);
    chk("pcplus4", pc_plus4, 32'h44);

    // beq taken backwards
    branch = 1; zero = 1; imm_ext = 32'hFFFF_FFFE;
    tick();
    chk_st("beq_t", 32'h3C, 1'b1, 4'd1);
    idle();
    tick();
    chk_st("seq", 32'h40, 1'b0, 4'd1);

    branch = 1; zero = 0; imm_ext = 32'hFFFF_FFFE;
    tick();
    chk_st("beq_nt", 32'h44, 1'b0, 4'd1);

    idle(); branch_ne = 1; zero = 0; imm_ext = 32'h1;
    tick();
    chk_st("bne_t", 32'h4C, 1'b1, 4'd2);

    // jr beats jump
    idle(); jr = 1; rs_data = 32'h1000_0010; jump = 1; jump_addr = 26'h3;
    tick();
    chk_st("jr_pri", 32'h1000_0010, 1'b1, 4'd3);

    idle(); jump = 1; jump_addr = 26'h100;
    tick();
    chk_st("jump", 32'h1000_0400, 1'b1, 4'd4);

    idle(); jr = 1; rs_data = 32'h80;
    tick();
    chk_st("jr_ok", 32'h80, 1'b1, 4'd5);

    idle(); jr = 1; rs_data = 32'h202;
    tick();
    chk_st("jr_bad", 32'h80, 1'b0, 4'd5);
    chk("trap", {31'b0, trap}, 32'd1);
    chk("epc", epc, 32'h80);

    jr = 1; rs_data = 32'h100; jump = 1; jump_addr = 26'h7; branch = 1; zero = 1; imm_ext = 32'h8;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("trap_hold.pc", pc, 32'h80);
    end
    chk_st("trap_end", 32'h80, 1'b0, 4'd5);
    chk("trap_end.trap", {31'b0, trap}, 32'd1);
    chk("trap_end.epc", epc, 32'h80);

    idle(); rst = 0;
    tick();
    chk_st("trap_rst", 32'h0, 1'b0, 4'd0);
    chk("trap_rst.trap", {31'b0, trap}, 32'd0);
    chk("trap_rst.epc", epc, 32'd0);

    rst = 1; stall = 1; jump = 1; jump_addr = 26'h55;
    tick();
    chk_st("stall1", 32'h0, 1'b0, 4'd0);
    tick();
    chk_st("stall2", 32'h0, 1'b0, 4'd0);
    stall = 0;
    tick();
    chk_st("unstall", 32'h154, 1'b1, 4'd1);

    jump_addr = 26'h10; branch = 1; zero = 1; imm_ext = 32'h5;
    tick();
    chk_st("jmp_vs_br", 32'h40, 1'b1, 4'd2);

    idle();
    for (int i = 0; i < 20; i++) begin
      jump = 1; jump_addr = 26'(i + 1);
      tick();
    end
    chk_st("sat", 32'h50, 1'b1, 4'hF);
    idle();
    tick();
    chk_st("sat_idle", 32'h54, 1'b0, 4'hF);

    // PC wraps modulo 2^32
    jr = 1; rs_data = 32'hFFFF_FFFC;
    tick();
    chk("top.pc", pc, 32'hFFFF_FFFC);
    chk("top.pc4", pc_plus4, 32'h0);
    idle();
    tick();
    chk_st("wrap", 32'h0, 1'b0, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Program-counter register and next-PC selection for the CPU datapath. It sits directly downstream of the immediate sign-extender: it consumes the 32-bit extended immediate to form branch targets. It also accepts jump/jr controls from the decoder and drives the fetch address to instruction memory. It holds on stall, traps on a misaligned register-indirect target, and counts control-flow redirects.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned
- CNT_W, 16: width of the redirect counter
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-low reset
- stall_i  in  1  hold PC this cycle
- branch_i  in  1  current instruction is beq
- branch_ne_i  in  1  current instruction is bne
- zero_i  in  1  ALU zero flag for current instruction
- imm_ext_i  in  32  sign-extended immediate (word offset)
- jump_i  in  1  current instruction is j/jal
- jump_addr_i  in  26  instruction[25:0]
- jr_i  in  1  current instruction is jr
- rs_data_i  in  32  register value for jr target
- pc_o  out  32  current fetch address (registered)
- pc_plus4_o  out  32  pc_o + 4 (combinational, for jal link)
- redirect_o  out  1  registered; high for one cycle after a non-sequential PC update
- trap_o  out  1  high while in TRAP state
- epc_o  out  32  PC of the faulting jr; held in TRAP
- redirect_cnt_o  out  CNT_W  saturating count of redirects since reset

## Operation
- States: RUN, TRAP.
- Reset (rst_i=0 at edge) has top priority:
  - pc_o=RESET_PC, state=RUN, trap_o=0, epc_o=0, redirect_o=0, redirect_cnt_o=0.
- RUN next-PC priority, highest first:
  - stall_i: hold pc_o. No redirect. Controls are ignored this cycle.
  - jr_i: if rs_data_i[1:0]≠0, go to TRAP. epc_o←pc_o and pc_o is held. Otherwise pc_o←rs_data_i.
  - jump_i: pc_o←{pc_plus4_o[31:28], jump_addr_i, 2'b00}.
  - Branch taken, i.e. (branch_i & zero_i) | (branch_ne_i & ~zero_i): pc_o←pc_plus4_o + (imm_ext_i<<2).
  - Otherwise: pc_o←pc_plus4_o.
- Arithmetic:
  - All adds are 32-bit modulo 2^32 and wrap silently.
  - imm_ext_i<<2 discards the top two bits.
- Multiple controls asserted together: the priority order above decides. This is not an error.
- Redirect: any jr (aligned), jump or taken-branch update that is not stalled.
  - Sets redirect_o for the next cycle only.
  - Increments redirect_cnt_o, which saturates at all-ones.
  - A taken branch whose target equals pc_plus4_o still counts as a redirect.
- TRAP:
  - pc_o, epc_o and the counter are frozen. trap_o=1. All inputs except rst_i are ignored.
  - The only exit is reset.
- An alignment fault does not count as a redirect.

## Timing
- Decisions are combinational on current inputs and pc_o. The new pc_o is visible one cycle after the edge: 1-cycle latency.
- redirect_o is asserted during the cycle in which the redirected pc_o is first presented.
- trap_o and epc_o become valid the cycle after the faulting edge.
- Reset mid-stall or mid-TRAP takes effect at the next edge.
- pc_plus4_o tracks pc_o with no added delay.

## Structure
- Shared package holds:
  - the state enum (RUN, TRAP)
  - the default RESET_PC
  - the INSTR_BYTES=4 constant
- One combinational sub-module, branch_target_calc:
  - Inputs: pc_plus4, imm_ext, jump_addr.
  - Outputs: branch target and jump target.
- The top level holds the FSM, the PC register, the epc register and the counter.

## Test plan
- Reset then 3 free-run cycles: pc_o goes 0 → 4 → 8 → 12. redirect_o=0 and redirect_cnt_o=0 throughout.
- pc_o=0x40, beq with zero_i=1, imm_ext_i=0xFFFF_FFFE: next pc_o=0x3C, redirect_o=1 for 1 cycle, count=1. The same beq with zero_i=0 gives pc_o=0x44.
- pc_o=0x1000_0010, jump_i=1, jump_addr_i=0x000_0100: next pc_o=0x1000_0400.
- jr_i=1 with rs_data_i=0x0000_0202 at pc_o=0x80:
  - trap_o=1, epc_o=0x80, pc_o stays 0x80 for 10 cycles despite branch/jump inputs.
  - rst_i=0 for one edge returns pc_o=0 and trap_o=0.
- stall_i=1 together with jump_i=1 for 2 cycles: pc_o is unchanged and count is unchanged. Releasing the stall while jump_i is held takes the jump.
- jump_i and branch_i both taken in the same cycle: the jump target wins. Counter preset to all-ones by repeated redirects (CNT_W=4) stays at 4'hF after 20 redirects.
